// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned IMEM_DEPTH  = 512;
    localparam int unsigned IMEM_ADDR_W = 9;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StFlush = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; emits a one-cycle word_valid
// the cycle after the fourth byte of a word is accepted.
module byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        byte_last,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;

    assign byte_last = in_valid && (cnt_q == 2'd3);

    always_comb begin
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = 1'b0;
        // A clear discards any partial word, including a byte arriving in the same cycle.
        if (clear) begin
            cnt_d = 2'd0;
        end else if (in_valid) begin
            word_d  = {in_data, word_q[31:8]};
            cnt_d   = cnt_q + 2'd1;
            valid_d = (cnt_q == 2'd3);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid = valid_q;
    assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a host byte program into the Icache write port and holds the core in reset
// until the whole program has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len_words,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_din,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       checksum
);

    localparam logic [ADDR_W:0] DepthL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] OneL   = (ADDR_W + 1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         checksum_q, checksum_d;
    logic                err_q, err_d;

    logic        active, abort_act, start_act, len_ok, start_go;
    logic        accept, byte_last, word_valid, last_word;
    logic [31:0] word;

    assign active    = (state_q == StLoad) || (state_q == StFlush);
    assign abort_act = abort && active;
    assign start_act = start && !active;
    assign len_ok    = (len_words != '0) && (len_words <= DepthL);
    assign start_go  = start_act && len_ok;
    assign accept    = s_valid && s_ready;
    // addr_q has already advanced past every earlier word by the time byte 3 arrives.
    assign last_word = (({1'b0, addr_q} + OneL) == len_q);

    byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_go || abort_act),
        .in_valid   (accept),
        .in_data    (s_data),
        .byte_last  (byte_last),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_act) state_d = len_ok ? StLoad : StIdle;
            end
            StLoad: begin
                if (abort) state_d = StIdle;
                else if (byte_last && last_word) state_d = StFlush;
            end
            StFlush: state_d = abort ? StIdle : StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s_ready   = (state_q == StLoad);
        busy      = active;
        done      = (state_q == StDone);
        core_hold = (state_q != StDone);
    end

    always_comb begin
        len_d      = len_q;
        addr_d     = addr_q;
        checksum_d = checksum_q;
        err_d      = err_q;
        if (word_valid) begin
            checksum_d = checksum_q + word;
            // The final write happens in FLUSH; holding the index there prevents a wrap.
            if (state_q == StLoad) addr_d = addr_q + 1'b1;
        end
        if (abort_act) err_d = 1'b1;
        if (start_act) begin
            if (len_ok) begin
                len_d      = len_words;
                addr_d     = '0;
                checksum_d = '0;
                err_d      = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            addr_q     <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
        end else begin
            len_q      <= len_d;
            addr_q     <= addr_d;
            checksum_q <= checksum_d;
            err_q      <= err_d;
        end
    end

    assign imem_we   = word_valid;
    assign imem_addr = addr_q;
    assign imem_din  = word;
    assign err       = err_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a byte-stream/word-list model.
module tb_imem_loader;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len_words = '0;
    logic              abort = 1'b0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = '0;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_din;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       checksum;

    int n_checks = 0;
    int n_pass   = 0;

    int unsigned wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] exp_words[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len_words (len_words),
        .abort     (abort),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_din  (imem_din),
        .core_hold (core_hold),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .checksum  (checksum)
    );

    // Capture every Icache write, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(int'(imem_addr));
            wr_data.push_back(imem_din);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int len);
        start     = 1'b1;
        len_words = (ADDR_W + 1)'(len);
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (s_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (s_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL send_timeout s_ready=%b required=1", s_ready);
        end
        step();
        s_valid = 1'b0;
    endtask

    // Sends nwords random words (max_gap idle cycles between bytes) and records the model words.
    task automatic send_words(input int nwords, input int max_gap);
        exp_words.delete();
        for (int w = 0; w < nwords; w++) begin
            logic [7:0] b [4];
            for (int k = 0; k < 4; k++) b[k] = 8'($urandom_range(0, 255));
            exp_words.push_back(32'(b[0]) + (32'(b[1]) << 8) + (32'(b[2]) << 16) +
                                (32'(b[3]) << 24));
            for (int k = 0; k < 4; k++) begin
                send_byte(b[k]);
                if (max_gap > 0) repeat ($urandom_range(0, max_gap)) step();
            end
        end
    endtask

    function automatic logic [31:0] model_sum();
        logic [31:0] s = 32'd0;
        foreach (exp_words[i]) s = s + exp_words[i];
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({core_hold, s_ready, imem_we, busy, done, err} !== 6'b100000)
            $display("FAIL reset_flags got=%b required=100000",
                     {core_hold, s_ready, imem_we, busy, done, err});
        else n_pass++;
        n_checks++;
        if ({imem_addr, imem_din, checksum} !== '0)
            $display("FAIL reset_data addr=%0h din=%0h sum=%0h required all 0",
                     imem_addr, imem_din, checksum);
        else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_one_word();
        wr_addr.delete();
        wr_data.delete();
        pulse_start(1);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        n_checks++;
        if ({imem_we, s_ready, busy} !== 3'b101)
            $display("FAIL one_write_cycle we/ready/busy=%b required=101",
                     {imem_we, s_ready, busy});
        else n_pass++;
        n_checks++;
        if (imem_addr !== 9'd0 || imem_din !== 32'h12345678)
            $display("FAIL one_write_data addr=%0h din=%0h required addr=0 din=12345678",
                     imem_addr, imem_din);
        else n_pass++;
        step();
        n_checks++;
        if ({done, core_hold, busy, imem_we} !== 4'b1000)
            $display("FAIL one_done done/hold/busy/we=%b required=1000",
                     {done, core_hold, busy, imem_we});
        else n_pass++;
        n_checks++;
        if (checksum !== 32'h12345678)
            $display("FAIL one_checksum got=%0h required=12345678", checksum);
        else n_pass++;
        n_checks++;
        if (wr_addr.size() != 1)
            $display("FAIL one_write_count got=%0d required=1", wr_addr.size());
        else n_pass++;
    endtask

    task automatic test_three_words_gaps();
        wr_addr.delete();
        wr_data.delete();
        pulse_start(3);
        send_words(3, 3);
        repeat (3) step();
        n_checks++;
        if (wr_addr.size() != 3)
            $display("FAIL gaps_write_count got=%0d required=3", wr_addr.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            n_checks++;
            if (wr_addr[i] != i || wr_data[i] !== exp_words[i])
                $display("FAIL gaps_write%0d addr=%0d din=%0h required addr=%0d din=%0h",
                         i, wr_addr[i], wr_data[i], i, exp_words[i]);
            else n_pass++;
        end
        n_checks++;
        if (checksum !== model_sum())
            $display("FAIL gaps_checksum got=%0h required=%0h", checksum, model_sum());
        else n_pass++;
        n_checks++;
        if ({done, core_hold, err} !== 3'b100)
            $display("FAIL gaps_done done/hold/err=%b required=100", {done, core_hold, err});
        else n_pass++;
    endtask

    task automatic test_bad_len();
        int bad [2];
        bad[0] = 0;
        bad[1] = DEPTH + 1;
        foreach (bad[i]) begin
            wr_addr.delete();
            pulse_start(bad[i]);
            repeat (2) step();
            n_checks++;
            if ({err, done, busy, core_hold, s_ready} !== 5'b10010)
                $display("FAIL badlen_%0d err/done/busy/hold/ready=%b required=10010",
                         bad[i], {err, done, busy, core_hold, s_ready});
            else n_pass++;
            n_checks++;
            if (wr_addr.size() != 0)
                $display("FAIL badlen_%0d_writes got=%0d required=0", bad[i], wr_addr.size());
            else n_pass++;
        end
        pulse_start(1);
        n_checks++;
        if ({err, busy} !== 2'b01)
            $display("FAIL badlen_recover err/busy=%b required=01", {err, busy});
        else n_pass++;
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        logic [31:0] w0;
        wr_addr.delete();
        wr_data.delete();
        pulse_start(2);
        send_words(1, 0);
        w0 = exp_words[0];
        send_byte(8'($urandom_range(0, 255)));
        send_byte(8'($urandom_range(0, 255)));
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++;
        if ({err, core_hold, s_ready, busy, done} !== 5'b11000)
            $display("FAIL abort_flags err/hold/ready/busy/done=%b required=11000",
                     {err, core_hold, s_ready, busy, done});
        else n_pass++;
        repeat (4) step();
        n_checks++;
        if (wr_addr.size() != 1 || wr_addr[0] != 0 || wr_data[0] !== w0)
            $display("FAIL abort_writes count=%0d required=1 (addr 0 din %0h)",
                     wr_addr.size(), w0);
        else n_pass++;
        wr_addr.delete();
        wr_data.delete();
        pulse_start(1);
        send_words(1, 0);
        step();
        n_checks++;
        if (wr_addr.size() != 1 || wr_addr[0] != 0 || wr_data[0] !== exp_words[0])
            $display("FAIL abort_reload count=%0d required=1 write at addr 0 din %0h",
                     wr_addr.size(), exp_words[0]);
        else n_pass++;
        n_checks++;
        if ({done, err} !== 2'b10)
            $display("FAIL abort_reload_done done/err=%b required=10", {done, err});
        else n_pass++;
    endtask

    task automatic test_full_load();
        int bad_writes = 0;
        wr_addr.delete();
        wr_data.delete();
        pulse_start(DEPTH);
        send_words(DEPTH, 0);
        repeat (3) step();
        n_checks++;
        if (wr_addr.size() != DEPTH)
            $display("FAIL full_write_count got=%0d required=%0d", wr_addr.size(), DEPTH);
        else n_pass++;
        for (int i = 0; i < wr_addr.size() && i < DEPTH; i++)
            if (wr_addr[i] != i || wr_data[i] !== exp_words[i]) bad_writes++;
        n_checks++;
        if (bad_writes != 0)
            $display("FAIL full_write_content bad=%0d required=0", bad_writes);
        else n_pass++;
        n_checks++;
        if (imem_addr !== 9'(DEPTH - 1) || done !== 1'b1)
            $display("FAIL full_end addr=%0d done=%b required addr=%0d done=1",
                     imem_addr, done, DEPTH - 1);
        else n_pass++;
        n_checks++;
        if (checksum !== model_sum())
            $display("FAIL full_checksum got=%0h required=%0h", checksum, model_sum());
        else n_pass++;
        pulse_start(1);
        n_checks++;
        if ({core_hold, done, busy} !== 3'b101)
            $display("FAIL restart_from_done hold/done/busy=%b required=101",
                     {core_hold, done, busy});
        else n_pass++;
    endtask

    task automatic test_reset_mid_word();
        wr_addr.delete();
        send_byte(8'($urandom_range(0, 255)));
        send_byte(8'($urandom_range(0, 255)));
        rst = 1'b1;
        #1;
        n_checks++;
        if ({core_hold, s_ready, imem_we, busy, done, err} !== 6'b100000 ||
            {imem_addr, imem_din, checksum} !== '0)
            $display("FAIL midreset flags=%b addr=%0h din=%0h sum=%0h required 100000/0/0/0",
                     {core_hold, s_ready, imem_we, busy, done, err}, imem_addr, imem_din,
                     checksum);
        else n_pass++;
        step();
        rst = 1'b0;
        repeat (4) step();
        n_checks++;
        if (wr_addr.size() != 0)
            $display("FAIL midreset_writes got=%0d required=0", wr_addr.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_one_word();
        test_three_words_gaps();
        test_bad_len();
        test_abort();
        test_full_load();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
